vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 141 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync/video decode and an
// optional delay line so every raster output shares the same fixed latency.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CNT_W    = 10,
    parameter int FC_W     = 8,
    parameter int PIPE_DLY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             videoon,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic [FC_W-1:0]  frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int D_W     = 5 + 2 * CNT_W;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [FC_W-1:0]  FC_ONE   = FC_W'(1);
    localparam logic             HS_ON    = 1'(HS_POL);
    localparam logic             VS_ON    = 1'(VS_POL);

    // Blanked, sync-inactive decode used for reset of every delay stage
    localparam logic [D_W-1:0] IDLE = {~HS_ON, ~VS_ON, 3'b000, {(2 * CNT_W){1'b0}}};

    if ((H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 8) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be 0..8");
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
        $error("vga_timing_gen: porch and sync widths must be non-zero");
    end

    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
    logic [D_W-1:0]   dec;
    logic [D_W-1:0]   pipe_out;
    logic [D_W-1:0]   out_q;
    logic             hs_act;
    logic             vs_act;
    logic             video;

    // Raster position counters; vc steps only at the end of a line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (en) begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + CNT_ONE;
            end else begin
                hc <= hc + CNT_ONE;
            end
        end
    end

    // Frame counter is undelayed: it steps on the edge where vc wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (en && hc == H_LAST && vc == V_LAST) begin
            frame_cnt <= frame_cnt + FC_ONE;
        end
    end

    // Region decode of the current position
    always_comb begin
        hs_act = (hc >= HS_START) && (hc <= HS_END);
        vs_act = (vc >= VS_START) && (vc <= VS_END);
        video  = (hc < H_VIS) && (vc < V_VIS);
        dec    = {hs_act ? HS_ON : ~HS_ON,
                  vs_act ? VS_ON : ~VS_ON,
                  video,
                  hc == '0,
                  (hc == '0) && (vc == '0),
                  hc,
                  vc};
    end

    if (PIPE_DLY == 0) begin : g_no_dly
        assign pipe_out = dec;
    end else begin : g_dly
        logic [D_W-1:0] stage [PIPE_DLY];

        // Enable-gated shift register carrying the whole decode bundle
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < PIPE_DLY; i++) begin
                    stage[i] <= IDLE;
                end
            end else if (en) begin
                stage[0] <= dec;
                for (int i = 1; i < PIPE_DLY; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign pipe_out = stage[PIPE_DLY-1];
    end

    // Output register; holding it while en=0 keeps the start strobes high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= IDLE;
        end else if (en) begin
            out_q <= pipe_out;
        end
    end

    assign {hsync, vsync, videoon, line_start, frame_start, x, y} = out_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a 8x6 raster: three instances
// (no delay, PIPE_DLY=3, inverted polarity with 2-bit frame counter).
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       vid;
        logic       ls;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
    } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic en    = 1'b0;

    always #5 clk = ~clk;

    logic       hs0, vs0, vid0, ls0, fs0;
    logic [9:0] x0, y0;
    logic [7:0] fc0;
    logic       hs3, vs3, vid3, ls3, fs3;
    logic [9:0] x3, y3;
    logic [7:0] fc3;
    logic       hsp, vsp, vidp, lsp, fsp;
    logic [9:0] xp, yp;
    logic [1:0] fcp;

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .HS_POL(0), .VS_POL(0), .CNT_W(10), .FC_W(8), .PIPE_DLY(0))
    u_d0 (.clk(clk), .reset(reset), .en(en), .hsync(hs0), .vsync(vs0), .videoon(vid0),
          .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0));

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .HS_POL(0), .VS_POL(0), .CNT_W(10), .FC_W(8), .PIPE_DLY(3))
    u_d3 (.clk(clk), .reset(reset), .en(en), .hsync(hs3), .vsync(vs3), .videoon(vid3),
          .x(x3), .y(y3), .line_start(ls3), .frame_start(fs3), .frame_cnt(fc3));

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .HS_POL(1), .VS_POL(1), .CNT_W(10), .FC_W(2), .PIPE_DLY(0))
    u_pol (.clk(clk), .reset(reset), .en(en), .hsync(hsp), .vsync(vsp), .videoon(vidp),
           .x(xp), .y(yp), .line_start(lsp), .frame_start(fsp), .frame_cnt(fcp));

    obs_t o0, o3, op;
    assign o0 = {hs0, vs0, vid0, ls0, fs0, x0, y0};
    assign o3 = {hs3, vs3, vid3, ls3, fs3, x3, y3};
    assign op = {hsp, vsp, vidp, lsp, fsp, xp, yp};

    int   total = 0;
    int   bad   = 0;
    int   mhc, mvc, mfc;
    obs_t q0[$];
    obs_t q3[$];
    obs_t qp[$];

    // Expected raster outputs for position (h,v): sync at x=5,6 / y=4, video x<4 && y<3
    function automatic obs_t model(input int h, input int v, input bit pol);
        obs_t o;
        o.hs  = (h == 5 || h == 6) ? pol : ~pol;
        o.vs  = (v == 4) ? pol : ~pol;
        o.vid = (h < 4) && (v < 3);
        o.ls  = (h == 0);
        o.fs  = (h == 0) && (v == 0);
        o.x   = 10'(h);
        o.y   = 10'(v);
        return o;
    endfunction

    function automatic obs_t idle(input bit pol);
        obs_t o;
        o    = '0;
        o.hs = ~pol;
        o.vs = ~pol;
        return o;
    endfunction

    task automatic adv();
        if (mhc == 7) begin
            mhc = 0;
            if (mvc == 5) begin
                mvc = 0;
                mfc = mfc + 1;
            end else begin
                mvc = mvc + 1;
            end
        end else begin
            mhc = mhc + 1;
        end
    endtask

    task automatic start();
        reset = 1'b1;
        en    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mhc = 0;
        mvc = 0;
        mfc = 0;
        q0.delete();
        q3.delete();
        qp.delete();
        repeat (3) q3.push_back(idle(1'b0));
    endtask

    // One clock with enable e; enabled ticks push the expected decode for every instance
    task automatic tick(input bit e);
        en = e;
        if (e) begin
            q0.push_back(model(mhc, mvc, 1'b0));
            q3.push_back(model(mhc, mvc, 1'b0));
            qp.push_back(model(mhc, mvc, 1'b1));
            adv();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (o0 !== idle(1'b0)) begin bad++; $display("FAIL reset_async_d0 got=%h exp=%h", o0, idle(1'b0)); end
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (o0 !== idle(1'b0)) begin bad++; $display("FAIL reset_d0 got=%h exp=%h", o0, idle(1'b0)); end
        total++;
        if (o3 !== idle(1'b0)) begin bad++; $display("FAIL reset_d3 got=%h exp=%h", o3, idle(1'b0)); end
        total++;
        if (op !== idle(1'b1)) begin bad++; $display("FAIL reset_pol got=%h exp=%h", op, idle(1'b1)); end
        total++;
        if (fc0 !== 8'd0 || fcp !== 2'd0) begin bad++; $display("FAIL reset_fc got=%0d/%0d exp=0/0", fc0, fcp); end
        en = 1'b0;
    endtask

    task automatic test_frame();
        obs_t e;
        start();
        for (int k = 0; k < 60; k++) begin
            tick(1'b1);
            e = q0.pop_front();
            total++;
            if (o0 !== e) begin bad++; $display("FAIL frame_d0 tick=%0d got=%h exp=%h", k, o0, e); end
            total++;
            if (fc0 !== 8'(mfc)) begin bad++; $display("FAIL frame_cnt_d0 tick=%0d got=%0d exp=%0d", k, fc0, mfc); end
        end
    endtask

    task automatic test_pipe();
        obs_t e;
        start();
        for (int k = 0; k < 60; k++) begin
            tick(1'b1);
            e = q3.pop_front();
            total++;
            if (o3 !== e) begin bad++; $display("FAIL pipe_d3 tick=%0d got=%h exp=%h", k, o3, e); end
            total++;
            if (fc3 !== 8'(mfc)) begin bad++; $display("FAIL pipe_fc_d3 tick=%0d got=%0d exp=%0d", k, fc3, mfc); end
        end
    endtask

    task automatic test_en_toggle();
        obs_t held0, held3;
        bit   e;
        start();
        held0 = idle(1'b0);
        held3 = idle(1'b0);
        for (int k = 0; k < 120; k++) begin
            e = (k % 4 == 0) || (k % 4 == 3);
            tick(e);
            if (e) begin
                held0 = q0.pop_front();
                held3 = q3.pop_front();
            end
            total++;
            if (o0 !== held0) begin bad++; $display("FAIL en_hold_d0 clk=%0d got=%h exp=%h", k, o0, held0); end
            total++;
            if (o3 !== held3) begin bad++; $display("FAIL en_hold_d3 clk=%0d got=%h exp=%h", k, o3, held3); end
            total++;
            if (fc0 !== 8'(mfc)) begin bad++; $display("FAIL en_hold_fc clk=%0d got=%0d exp=%0d", k, fc0, mfc); end
        end
    endtask

    task automatic test_reset_mid();
        obs_t e;
        bit   found;
        start();
        found = 1'b0;
        for (int k = 0; k < 120 && !found; k++) begin
            tick(1'b1);
            e = q0.pop_front();
            if (k >= 48 && o0.y == 10'd4 && o0.x == 10'd6 && o0.vs == 1'b0) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL reset_mid_search got=%h exp=vsync0_x6", o0); end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (o0 !== idle(1'b0)) begin bad++; $display("FAIL reset_mid_d0 got=%h exp=%h", o0, idle(1'b0)); end
        total++;
        if (o3 !== idle(1'b0)) begin bad++; $display("FAIL reset_mid_d3 got=%h exp=%h", o3, idle(1'b0)); end
        total++;
        if (fc0 !== 8'd0) begin bad++; $display("FAIL reset_mid_fc got=%0d exp=0", fc0); end
        #1;
        reset = 1'b0;
        mhc = 0;
        mvc = 0;
        mfc = 0;
        q0.delete();
        for (int k = 0; k < 12; k++) begin
            tick(1'b1);
            e = q0.pop_front();
            total++;
            if (o0 !== e) begin bad++; $display("FAIL reset_mid_after tick=%0d got=%h exp=%h", k, o0, e); end
        end
    endtask

    task automatic test_polarity();
        obs_t e;
        start();
        for (int k = 0; k < 200; k++) begin
            tick(1'b1);
            e = qp.pop_front();
            total++;
            if (op !== e) begin bad++; $display("FAIL pol tick=%0d got=%h exp=%h", k, op, e); end
            total++;
            if (fcp !== 2'(mfc)) begin bad++; $display("FAIL pol_fc tick=%0d got=%0d exp=%0d", k, fcp, mfc % 4); end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_pipe();
        test_en_toggle();
        test_reset_mid();
        test_polarity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
